muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the MIPS core, sitting beside the single-cycle ALU and owning the HI/LO result pair for MULT, MULTU, DIV and DIVU. It accepts one operation per start pulse and computes it over WIDTH clock cycles. It holds its results in HI/LO until the next operation completes. It signals busy/done so the pipeline can stall on mfhi/mflo.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_sign_fix.sv | 15 +
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: op encodings,
// FSM state codes and the default operand width.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation, used both to take operand
// magnitudes and to restore the sign of the final results.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int W = DEFAULT_WIDTH
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair: shift-add
// multiply and restoring divide, one bit per cycle on operand magnitudes.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div_q;
  logic               dz_q;
  logic               q_neg;
  logic               r_neg;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dsr;

  logic               op_signed;
  logic               op_div;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;

  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIVU) || (op == OP_DIV);
  assign busy      = (state != IDLE);

  muldiv_sign_fix #(.W(WIDTH)) u_mag_a (
    .neg  (op_signed & a[WIDTH-1]),
    .din  (a),
    .dout (mag_a)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_mag_b (
    .neg  (op_signed & b[WIDTH-1]),
    .din  (b),
    .dout (mag_b)
  );

  // Multiply step: add the multiplicand into the upper half when the current
  // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

  // Divide step: shift in the next dividend bit and keep the trial
  // subtraction only if it did not go negative.
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_ok    = div_shift >= {2'b00, dsr};
  assign div_diff  = div_shift[WIDTH:0] - {1'b0, dsr};

  muldiv_sign_fix #(.W(2*WIDTH)) u_prod_fix (
    .neg  (q_neg),
    .din  (acc),
    .dout (prod_res)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_quo_fix (
    .neg  (q_neg),
    .din  (quo),
    .dout (quo_res)
  );

  muldiv_sign_fix #(.W(WIDTH)) u_rem_fix (
    .neg  (r_neg),
    .din  (rem[WIDTH-1:0]),
    .dout (rem_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div_q    <= 1'b0;
      dz_q        <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      rem         <= '0;
      quo         <= '0;
      dsr         <= '0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div_q <= op_div;
            q_neg    <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg    <= op_signed & a[WIDTH-1];
            mcand    <= mag_a;
            acc      <= {{WIDTH{1'b0}}, mag_b};
            quo      <= mag_a;
            dsr      <= mag_b;
            cnt      <= LAST;
            // A zero divisor skips the iterations; parking |a| in the
            // remainder lets the remainder sign fix reproduce a for hi.
            if (op_div && (b == '0)) begin
              dz_q  <= 1'b1;
              rem   <= {1'b0, mag_a};
              state <= FINISH;
            end else begin
              dz_q  <= 1'b0;
              rem   <= '0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (is_div_q) begin
            rem <= div_ok ? div_diff : div_shift[WIDTH:0];
            quo <= {quo[WIDTH-2:0], div_ok};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          if (cnt == '0) begin
            state <= FINISH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FINISH: begin
          if (is_div_q) begin
            hi <= rem_res;
            lo <= dz_q ? '1 : quo_res;
          end else begin
            hi <= prod_res[2*WIDTH-1:WIDTH];
            lo <= prod_res[WIDTH-1:0];
          end
          div_by_zero <= is_div_q & dz_q;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a reference model pushes expected HI/LO,
// flag and completion cycle per accepted op; a monitor pops them on done.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           doneCyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int   tests = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model built on 64-bit native arithmetic (C-style truncating
  // signed division gives the MIPS quotient/remainder signs directly).
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input int t0);
    exp_t        e;
    longint      sx;
    longint      sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dz = 1'b0;
    e.doneCyc = t0 + W + 1;
    e.hi = '0;
    e.lo = '0;
    if (o == OP_MULTU) begin
      p = {32'b0, x} * {32'b0, y};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (o == OP_MULT) begin
      p = sx * sy;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == '0) begin
      e.hi = x;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
      e.doneCyc = t0 + 1;
    end else if (o == OP_DIVU) begin
      e.lo = x / y;
      e.hi = x % y;
    end else begin
      p = sx / sy;
      e.lo = p[31:0];
      p = sx % sy;
      e.hi = p[31:0];
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input bit expectDone);
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (expectDone) sb.push_back(model(o, x, y, cyc));
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int expBusy);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) n++;
    end
    if (!seen) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
    else checkOutput({tag, "_busy_cycles"}, 64'(n), 64'(expBusy));
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (busy && done) checkOutput("busy_done_overlap", 64'd1, 64'd0);
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("hi", 64'(hi), 64'(e.hi));
          checkOutput("lo", 64'(lo), 64'(e.lo));
          checkOutput("div_by_zero", 64'(div_by_zero), 64'(e.dz));
          checkOutput("done_cycle", 64'(cyc), 64'(e.doneCyc));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e1;
    bit   seen;
    int   doneCount;
    logic [1:0]   ro;
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_hi", 64'(hi), 64'd0);
    checkOutput("rst_lo", 64'(lo), 64'd0);
    checkOutput("rst_dz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    waitDone("multu_max", W + 1);
    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1);
    waitDone("mult_neg", W + 1);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    waitDone("div_neg", W + 1);
    applyStimulus(OP_DIVU, 32'd12, 32'd10, 1'b1);
    waitDone("divu", W + 1);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    waitDone("div_ovf", W + 1);
    applyStimulus(OP_DIVU, 32'd5, 32'd0, 1'b1);
    waitDone("div_zero", 1);
    applyStimulus(OP_MULTU, 32'd2, 32'd3, 1'b1);
    waitDone("clear_dz", W + 1);

    // A second start with new operands mid-operation must be ignored.
    applyStimulus(OP_MULTU, 32'd7, 32'd9, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op = OP_DIVU;
    a = 32'd100;
    b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    a = 32'd1;
    b = 32'd1;
    waitDone("ignore_start", W + 1 - 5);

    // Back-to-back: start held through the done cycle.
    @(negedge clk);
    op = OP_MULT;
    a = 32'(-1234);
    b = 32'd5678;
    start = 1'b1;
    @(posedge clk);
    #1;
    e1 = model(OP_MULT, 32'(-1234), 32'd5678, cyc);
    sb.push_back(e1);
    op = OP_DIVU;
    a = 32'd1000;
    b = 32'd7;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("b2b_first_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    checkOutput("b2b_busy", 64'(busy), 64'd1);
    checkOutput("b2b_hold_hi", 64'(hi), 64'(e1.hi));
    checkOutput("b2b_hold_lo", 64'(lo), 64'(e1.lo));
    sb.push_back(model(OP_DIVU, 32'd1000, 32'd7, cyc));
    start = 1'b0;
    waitDone("b2b_second", W + 1);

    // Reset partway through a divide aborts it with no done pulse.
    applyStimulus(OP_DIV, 32'hFFFF_0001, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_hi", 64'(hi), 64'd0);
    checkOutput("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("abort_no_done", 64'(doneCount), 64'd0);
    applyStimulus(OP_DIV, 32'(-100), 32'd7, 1'b1);
    waitDone("after_abort", W + 1);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if (i % 3 == 1) ry = ry >> $urandom_range(0, 28);
      if (i == 2) begin
        ro = OP_DIV;
        ry = '0;
      end
      applyStimulus(ro, rx, ry, 1'b1);
      waitDone("random", (ro[1] && ry == '0) ? 1 : W + 1);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
